// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit common-anode 7-segment scan driver:
// segment table, all-off codes and the slot phase type.
package seg7_pkg;

    localparam int N_DIG = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp held inactive here, merged in by the decoder.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_e;

    function automatic logic [7:0] an_select(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with active-high decimal point input;
// all outputs active-low.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    output logic [7:0] seg
);

    logic [7:0] base_s;

    // Table lookup, then overlay the decimal point on bit 7.
    always_comb begin
        base_s = HEX_SEG[nibble];
        seg    = {~point, base_s[6:0]};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit scan driver: latches the display word at frame
// boundaries, blanks anodes at the start of each slot and blinks selected digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  LE_in,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_tick
);

    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [31:0]      num_r;
    logic [7:0]       point_r;
    logic [7:0]       le_r;
    logic [BLK_W-1:0] blink_cnt_r;
    logic             blink_phase_r;
    logic [7:0]       an_r;
    logic [7:0]       seg_r;
    logic             tick_r;

    logic             slot_end_s;
    logic             frame_end_s;
    logic [3:0]       nibble_s;
    logic             point_s;
    logic             blank_s;
    logic [7:0]       dec_seg_s;
    slot_e            slot_s;
    logic [7:0]       an_nxt_s;
    logic [7:0]       seg_nxt_s;

    assign slot_end_s  = (cnt_r == CNT_W'(SCAN_DIV - 1));
    assign frame_end_s = slot_end_s && (idx_r == 3'(N_DIG - 1));
    assign nibble_s    = num_r[{idx_r, 2'b00} +: 4];
    assign point_s     = point_r[idx_r];
    assign blank_s     = le_r[idx_r] & ~blink_phase_r;

    seg7_hex_decode u_dec (
        .nibble (nibble_s),
        .point  (point_s),
        .seg    (dec_seg_s)
    );

    // Slot phase and next output values; idx only moves while the slot is in GUARD.
    always_comb begin
        slot_s    = SLOT_GUARD;
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_OFF;
        if (cnt_r < CNT_W'(GUARD)) begin
            slot_s = SLOT_GUARD;
        end else begin
            slot_s = SLOT_DRIVE;
        end
        case (slot_s)
            SLOT_GUARD: begin
                an_nxt_s  = AN_OFF;
                seg_nxt_s = SEG_OFF;
            end
            SLOT_DRIVE: begin
                an_nxt_s  = an_select(idx_r);
                if (blank_s) begin
                    seg_nxt_s = SEG_OFF;
                end else begin
                    seg_nxt_s = dec_seg_s;
                end
            end
            default: begin
                an_nxt_s  = AN_OFF;
                seg_nxt_s = SEG_OFF;
            end
        endcase
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= 3'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Shadow registers and frame tick, updated only at an enabled frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r   <= 32'h0000_0000;
            point_r <= 8'h00;
            le_r    <= 8'h00;
            tick_r  <= 1'b0;
        end else if (frame_end_s && EN) begin
            num_r   <= Disp_num;
            point_r <= point_in;
            le_r    <= LE_in;
            tick_r  <= 1'b1;
        end else begin
            tick_r  <= 1'b0;
        end
    end

    // Blink timer runs on every frame boundary, independent of the latch enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (frame_end_s) begin
            if (blink_cnt_r == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BLK_W'(1);
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign AN         = an_r;
    assign SEGMENT    = seg_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-cycle slot, 2-cycle guard
// and 2-frame blink half-period (64 cycles per frame).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        EN = 1'b0;
    logic [31:0] Disp_num = 32'h0;
    logic [7:0]  point_in = 8'h00;
    logic [7:0]  LE_in = 8'h00;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;
    int k = -1;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV     (8),
        .GUARD        (2),
        .BLINK_FRAMES (2),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .EN         (EN),
        .Disp_num   (Disp_num),
        .point_in   (point_in),
        .LE_in      (LE_in),
        .AN         (AN),
        .SEGMENT    (SEGMENT),
        .frame_tick (frame_tick)
    );

    // k is the index of the last rising edge since reset release; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        k = k + 1;
    endtask

    task automatic test_reset();
        logic [31:0] word;
        rst = 1'b0;
        EN = 1'b1;
        word = 32'h7654_3210;
        Disp_num = word;
        point_in = 8'h00;
        LE_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (AN !== 8'hFF) begin
                miscompares++;
                $display("FAIL reset_an: got %h expected FF", AN);
            end
            vectors++;
            if (SEGMENT !== 8'hFF) begin
                miscompares++;
                $display("FAIL reset_seg: got %h expected FF", SEGMENT);
            end
            vectors++;
            if (frame_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_tick: got %b expected 0", frame_tick);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        k = -1;
    endtask

    // Frame 0 after reset: shadows are zero, so every digit shows 0.
    task automatic test_scan_zeros();
        logic [7:0] exp_an, exp_seg;
        for (int n = 0; n < 64; n++) begin
            step();
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
            if ((k % 8) >= 2) begin
                exp_an = ~(8'h01 << ((k / 8) % 8));
                exp_seg = 8'hC0;
            end
            vectors++;
            if (AN !== exp_an || SEGMENT !== exp_seg) begin
                miscompares++;
                $display("FAIL zeros k=%0d: AN=%h SEG=%h expected AN=%h SEG=%h", k, AN, SEGMENT, exp_an, exp_seg);
            end
            vectors++;
            if (frame_tick !== (k == 63)) begin
                miscompares++;
                $display("FAIL zeros_tick k=%0d: got %b expected %b", k, frame_tick, (k == 63));
            end
        end
    endtask

    // Frame 1 shows 76543210; new inputs applied mid-frame must not appear yet.
    task automatic test_hex_digits();
        logic [7:0] exp_an, exp_seg;
        int d;
        for (int n = 0; n < 64; n++) begin
            step();
            if (k == 70) begin
                Disp_num = 32'hFEDC_BA98;
                point_in = 8'h81;
            end
            d = (k / 8) % 8;
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
            if ((k % 8) >= 2) begin
                exp_an = ~(8'h01 << d);
                exp_seg = HEX_TAB[d];
            end
            vectors++;
            if (AN !== exp_an || SEGMENT !== exp_seg) begin
                miscompares++;
                $display("FAIL hex k=%0d: AN=%h SEG=%h expected AN=%h SEG=%h", k, AN, SEGMENT, exp_an, exp_seg);
            end
            vectors++;
            if (frame_tick !== (k == 127)) begin
                miscompares++;
                $display("FAIL hex_tick k=%0d: got %b expected %b", k, frame_tick, (k == 127));
            end
        end
    endtask

    // Frame 2 shows FEDCBA98 with decimal points on digits 0 and 7.
    task automatic test_points();
        logic [7:0] exp_an, exp_seg;
        int d;
        for (int n = 0; n < 64; n++) begin
            step();
            d = (k / 8) % 8;
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
            if ((k % 8) >= 2) begin
                exp_an = ~(8'h01 << d);
                exp_seg = HEX_TAB[8 + d];
                if (d == 0 || d == 7) exp_seg = exp_seg & 8'h7F;
            end
            vectors++;
            if (AN !== exp_an || SEGMENT !== exp_seg) begin
                miscompares++;
                $display("FAIL points k=%0d: AN=%h SEG=%h expected AN=%h SEG=%h", k, AN, SEGMENT, exp_an, exp_seg);
            end
            vectors++;
            if (frame_tick !== (k == 191)) begin
                miscompares++;
                $display("FAIL points_tick k=%0d: got %b expected %b", k, frame_tick, (k == 191));
            end
        end
    endtask

    // Frames 3-4 with EN low: content frozen and no tick; EN raised in frame 4.
    task automatic test_enable_hold();
        logic [7:0] exp_an, exp_seg;
        int d;
        for (int n = 0; n < 128; n++) begin
            step();
            if (k == 193) begin
                EN = 1'b0;
                Disp_num = 32'h0000_0000;
            end
            if (k == 254) begin
                Disp_num = 32'h1111_1111;
                point_in = 8'h00;
            end
            if (k == 300) begin
                EN = 1'b1;
                Disp_num = 32'h89AB_CDEF;
                point_in = 8'h00;
                LE_in = 8'h04;
            end
            d = (k / 8) % 8;
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
            if ((k % 8) >= 2) begin
                exp_an = ~(8'h01 << d);
                exp_seg = HEX_TAB[8 + d];
                if (d == 0 || d == 7) exp_seg = exp_seg & 8'h7F;
            end
            vectors++;
            if (AN !== exp_an || SEGMENT !== exp_seg) begin
                miscompares++;
                $display("FAIL hold k=%0d: AN=%h SEG=%h expected AN=%h SEG=%h", k, AN, SEGMENT, exp_an, exp_seg);
            end
            vectors++;
            if (frame_tick !== (k == 319)) begin
                miscompares++;
                $display("FAIL hold_tick k=%0d: got %b expected %b", k, frame_tick, (k == 319));
            end
        end
    endtask

    // Frames 5-9 show 89ABCDEF; digit 2 blinks (blank in frames 6 and 7).
    task automatic test_blink();
        logic [7:0] exp_an, exp_seg;
        int d, f;
        for (int n = 0; n < 320; n++) begin
            step();
            d = (k / 8) % 8;
            f = k / 64;
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
            if ((k % 8) >= 2) begin
                exp_an = ~(8'h01 << d);
                exp_seg = HEX_TAB[15 - d];
                if (d == 2 && ((f / 2) % 2) == 1) exp_seg = 8'hFF;
            end
            vectors++;
            if (AN !== exp_an || SEGMENT !== exp_seg) begin
                miscompares++;
                $display("FAIL blink k=%0d: AN=%h SEG=%h expected AN=%h SEG=%h", k, AN, SEGMENT, exp_an, exp_seg);
            end
            vectors++;
            if (frame_tick !== ((k % 64) == 63)) begin
                miscompares++;
                $display("FAIL blink_tick k=%0d: got %b expected %b", k, frame_tick, ((k % 64) == 63));
            end
        end
    endtask

    // Reset in the DRIVE part of digit 5 must blank outputs without a clock edge.
    task automatic test_async_reset();
        while ((k % 64) != 44) step();
        vectors++;
        if (AN !== 8'hDF || SEGMENT !== 8'h88) begin
            miscompares++;
            $display("FAIL pre_reset k=%0d: AN=%h SEG=%h expected AN=DF SEG=88", k, AN, SEGMENT);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (AN !== 8'hFF || SEGMENT !== 8'hFF) begin
            miscompares++;
            $display("FAIL async_reset: AN=%h SEG=%h expected AN=FF SEG=FF", AN, SEGMENT);
        end
        vectors++;
        if (frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_tick: got %b expected 0", frame_tick);
        end
        EN = 1'b1;
        Disp_num = 32'hCAFE_1234;
        point_in = 8'h00;
        LE_in = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        k = -1;
    endtask

    // Ten frames after restart: zeros first, then CAFE1234; anode invariants every cycle.
    task automatic test_restart_scan();
        logic [7:0] exp_an, exp_seg, prev_an;
        logic [31:0] word;
        int d;
        word = 32'hCAFE_1234;
        prev_an = 8'hFF;
        for (int n = 0; n < 640; n++) begin
            step();
            d = (k / 8) % 8;
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
            if ((k % 8) >= 2) begin
                exp_an = ~(8'h01 << d);
                exp_seg = (k < 64) ? 8'hC0 : HEX_TAB[word[4*d +: 4]];
            end
            vectors++;
            if (AN !== exp_an || SEGMENT !== exp_seg) begin
                miscompares++;
                $display("FAIL restart k=%0d: AN=%h SEG=%h expected AN=%h SEG=%h", k, AN, SEGMENT, exp_an, exp_seg);
            end
            vectors++;
            if ($countones(~AN) > 1) begin
                miscompares++;
                $display("FAIL an_onehot k=%0d: AN=%h expected at most one zero bit", k, AN);
            end
            vectors++;
            if (prev_an !== 8'hFF && AN !== 8'hFF && AN !== prev_an) begin
                miscompares++;
                $display("FAIL an_transition k=%0d: AN=%h after %h expected FF between digits", k, AN, prev_an);
            end
            vectors++;
            if (frame_tick !== ((k % 64) == 63)) begin
                miscompares++;
                $display("FAIL restart_tick k=%0d: got %b expected %b", k, frame_tick, ((k % 64) == 63));
            end
            prev_an = AN;
        end
    endtask

    initial begin
        test_reset();
        test_scan_zeros();
        test_hex_digits();
        test_points();
        test_enable_hold();
        test_blink();
        test_async_reset();
        test_restart_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
